// File: rtl/osc_capture_seq.sv
// rtl/osc_capture_seq.sv - oscilloscope capture sequencer with level trigger; optional tick decimation via OSC_DECIM_EN
module osc_capture_seq #(
    parameter int          NUM_CH    = 2,
    parameter int          PERIOD    = 2000,
    parameter int          DEPTH     = 100000,
    parameter logic [39:0] BASE_ADDR = 40'h00_0090_0000,
    parameter logic [39:0] STRIDE    = 40'h00_0010_0000,
    parameter int          CW        = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [NUM_CH*64-1:0] i_data,
    output logic                 o_start,
    input  logic                 i_done,
    output logic [39:0]          o_ddr_addr,
    output logic [63:0]          o_ddr_data,
    output logic [CW-1:0]        o_addr_cnt,
    input  logic [3:0]           i_trg_sel,
    input  logic [31:0]          i_trg_level,
    input  logic [CW-1:0]        i_post_cnt,
    input  logic                 i_trg_arm,
`ifdef OSC_DECIM_EN
    input  logic [15:0]          i_decim,
`endif
    output logic                 o_armed,
    output logic                 o_triggered,
    output logic                 o_frozen,
    output logic [CW-1:0]        o_trg_idx,
    output logic [31:0]          o_trg_buf,
    output logic                 o_overrun,
    output logic [2:0]           o_state
);

    localparam int TW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XFER = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;
    logic             w_tick_ok;
    logic [63:0]      r_snap [NUM_CH];
    logic [CHW-1:0]   r_ch;
    logic [CW-1:0]    r_addr_cnt;
    logic [CW-1:0]    r_post;
    logic [CW-1:0]    r_trg_idx;
    logic [31:0]      r_trg_buf;
    logic             r_armed;
    logic             r_triggered;
    logic             r_frozen;
    logic             r_overrun;
    logic [63:0]      w_cur_word;
    logic [63:0]      w_src_word;
    logic [31:0]      w_src;
    logic             w_fire;
    logic [39:0]      w_addr;
    logic             w_armed_nxt;
    logic             w_trg_nxt;
    logic             w_frz_nxt;
    logic [CW-1:0]    w_post_nxt;
    logic [CW-1:0]    w_trg_idx_nxt;

    assign w_tick = (r_tick_cnt == TW'(PERIOD - 1));

    // Free-running sample tick counter, independent of the FSM
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TW'(1);
    end

`ifdef OSC_DECIM_EN
    logic [15:0] r_decim_cnt;

    // Decimation counter: only every (i_decim+1)th tick may start a sample
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)      r_decim_cnt <= '0;
        else if (w_tick) r_decim_cnt <= (r_decim_cnt >= i_decim) ? 16'd0 : r_decim_cnt + 16'd1;
    end

    assign w_tick_ok = w_tick && (r_decim_cnt >= i_decim);
`else
    assign w_tick_ok = w_tick;
`endif

    // Select the snapshot word being written and the trigger-source word
    always_comb begin
        w_cur_word = r_snap[0];
        w_src_word = r_snap[0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == CHW'(k))             w_cur_word = r_snap[k];
            if (i_trg_sel[3:1] == 3'(k))     w_src_word = r_snap[k];
        end
    end

    assign w_src  = i_trg_sel[0] ? w_src_word[31:0] : w_src_word[63:32];
    assign w_fire = r_armed && ($signed(r_trg_buf) < $signed(i_trg_level))
                            && ($signed(i_trg_level) <= $signed(w_src));
    assign w_addr = BASE_ADDR + 40'(r_ch) * STRIDE + (40'(r_addr_cnt) << 3);

    // Trigger / post-count / freeze next-state; an arm pulse overrides a same-cycle fire
    always_comb begin
        w_armed_nxt   = r_armed;
        w_trg_nxt     = r_triggered;
        w_frz_nxt     = r_frozen;
        w_post_nxt    = r_post;
        w_trg_idx_nxt = r_trg_idx;
        if (r_state == S_DONE) begin
            if (r_triggered && !r_frozen) begin
                w_post_nxt = (r_post == '0) ? '0 : r_post - CW'(1);
                if (r_post <= CW'(1)) w_frz_nxt = 1'b1;
            end else if (w_fire) begin
                w_trg_nxt     = 1'b1;
                w_armed_nxt   = 1'b0;
                w_trg_idx_nxt = r_addr_cnt;
                w_post_nxt    = i_post_cnt;
                if (i_post_cnt == '0) w_frz_nxt = 1'b1;
            end
        end
        if (i_trg_arm) begin
            w_armed_nxt = 1'b1;
            w_trg_nxt   = 1'b0;
            w_frz_nxt   = 1'b0;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_tick_ok && i_en && !r_frozen) w_state_nxt = S_XFER;
            S_XFER: if (i_done) w_state_nxt = (r_ch == CHW'(NUM_CH - 1)) ? S_DONE : S_GAP;
            S_GAP:  w_state_nxt = S_XFER;
            S_DONE: w_state_nxt = w_frz_nxt ? S_HOLD : S_IDLE;
            S_HOLD: if (i_trg_arm) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Snapshot capture on sample start and channel walk through the GAP state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < NUM_CH; k++) r_snap[k] <= '0;
            r_ch <= '0;
        end else if (r_state == S_IDLE && w_state_nxt == S_XFER) begin
            for (int k = 0; k < NUM_CH; k++) r_snap[k] <= i_data[64*k +: 64];
            r_ch <= '0;
        end else if (r_state == S_GAP) begin
            r_ch <= r_ch + CHW'(1);
        end
    end

    // Per-sample bookkeeping: ring index, trigger registers and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr_cnt  <= '0;
            r_trg_buf   <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_frozen    <= 1'b0;
            r_post      <= '0;
            r_trg_idx   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_trg_buf  <= w_src;
                r_addr_cnt <= (r_addr_cnt == CW'(DEPTH - 1)) ? '0 : r_addr_cnt + CW'(1);
            end
            r_armed     <= w_armed_nxt;
            r_triggered <= w_trg_nxt;
            r_frozen    <= w_frz_nxt;
            r_post      <= w_post_nxt;
            r_trg_idx   <= w_trg_idx_nxt;
            if (i_trg_arm)
                r_overrun <= 1'b0;
            else if (w_tick_ok && (r_state == S_XFER || r_state == S_GAP || r_state == S_DONE))
                r_overrun <= 1'b1;
        end
    end

    assign o_start     = (r_state == S_XFER);
    assign o_ddr_addr  = (r_state == S_XFER) ? w_addr : '0;
    assign o_ddr_data  = (r_state == S_XFER) ? w_cur_word : '0;
    assign o_addr_cnt  = r_addr_cnt;
    assign o_armed     = r_armed;
    assign o_triggered = r_triggered;
    assign o_frozen    = r_frozen;
    assign o_trg_idx   = r_trg_idx;
    assign o_trg_buf   = r_trg_buf;
    assign o_overrun   = r_overrun;
    assign o_state     = r_state;

endmodule

// File: doc/osc_capture_seq.md
# osc_capture_seq

- Parametrised next-generation oscilloscope capture sequencer.
- On each sample tick it snapshots NUM_CH 64-bit channel words and writes them one at a time to per-channel DDR ring regions through the DDR writer's start/done handshake.
- Adds an armed rising-edge level trigger with a programmable post-trigger count that freezes the ring, plus overrun detection.
- Sits between the ADC/DC-link measurement pipeline and the DDR write master.

## Interface
Parameters:
- NUM_CH, 2: number of 64-bit channel words per sample (1..8)
- PERIOD, 2000: clocks per sample tick
- DEPTH, 100000: samples per channel ring
- BASE_ADDR, 40'h00_0090_0000: DDR byte address of channel 0 ring
- STRIDE, 40'h00_0010_0000: byte offset between channel rings
- CW, $clog2(DEPTH): sample counter width

Ports:
- i_clk  in  1  system clock (single clock domain)
- i_rst  in  1  asynchronous active-low reset
- i_en  in  1  capture enable; 0 forces IDLE after the current sample completes
- i_data  in  NUM_CH*64  channel words; word k = i_data[64k+63:64k], upper half current, lower half voltage
- o_start  out  1  DDR write request
- i_done  in  1  DDR write complete pulse
- o_ddr_addr  out  40  DDR byte address
- o_ddr_data  out  64  DDR write data
- o_addr_cnt  out  CW  ring write index of the current sample
- i_trg_sel  in  4  trigger source: bits[3:1] = channel, bit[0] 0 = upper half, 1 = lower half
- i_trg_level  in  32  signed trigger level
- i_post_cnt  in  CW  samples stored after the trigger sample
- i_trg_arm  in  1  arm pulse
- o_armed  out  1  trigger armed
- o_triggered  out  1  trigger has fired
- o_frozen  out  1  post-trigger capture finished, ring held
- o_trg_idx  out  CW  o_addr_cnt value of the trigger sample
- o_trg_buf  out  32  last sampled trigger-source word
- o_overrun  out  1  sticky: a tick arrived while the previous sample was still being written
- o_state  out  3  FSM state

## Operation
- Tick generator: free-running counter 0..PERIOD-1, not affected by the FSM. A tick is issued when the counter equals PERIOD-1.
- States:
  - IDLE=0, XFER=1, GAP=2, DONE=3, HOLD=4.
  - IDLE: on a tick with i_en=1 and not frozen, latch all of i_data into the snapshot, set ch=0 and go to XFER.
  - XFER: o_start=1.
    - o_ddr_addr = BASE_ADDR + ch*STRIDE + o_addr_cnt*8, computed at 40 bits.
    - o_ddr_data = snapshot word ch.
    - On i_done: go to DONE if ch==NUM_CH-1, otherwise go to GAP.
  - GAP: o_start=0 for one cycle; ch+1; return to XFER.
  - DONE:
    - o_trg_buf updates from the snapshot.
    - Trigger evaluation runs (see Trigger below).
    - o_addr_cnt advances, wrapping DEPTH-1 to 0.
    - Next state: HOLD if frozen, otherwise IDLE.
  - HOLD: ticks are ignored; i_trg_arm returns to IDLE.
- Trigger (evaluated in DONE, signed compare):
  - Fires when o_armed and prev < level <= cur, where prev is the previous DONE value of the source.
  - On firing: set o_triggered, clear o_armed, latch o_trg_idx = o_addr_cnt, load the post counter with i_post_cnt.
  - While o_triggered and not frozen: each later DONE decrements the post counter. When the counter is 0 at DONE, set o_frozen.
  - i_post_cnt=0: o_frozen is set in the same DONE as the trigger.
- i_trg_arm:
  - Sets o_armed and clears o_triggered and o_frozen.
  - Does not reset o_addr_cnt.
  - If it arrives in the same cycle as a trigger firing, the arm wins.
- Overrun: a tick seen in XFER, GAP or DONE sets o_overrun. The tick is dropped. o_overrun is cleared only by i_trg_arm.
- i_trg_sel selecting a channel ≥ NUM_CH: treated as channel 0.

## Timing
- Reset values:
  - All outputs are 0; state is IDLE.
  - Snapshot, prev and post counter are 0.
  - Not armed.
- o_start rises 1 cycle after the tick. Address and data are valid in the same cycle as o_start and stay stable until the cycle after i_done.
- i_done is sampled only in XFER.
- A sample takes NUM_CH*(1+Tdone) + (NUM_CH-1) + 1 cycles, where Tdone is the DDR write latency.
- o_addr_cnt, o_triggered and o_frozen update on the clock edge leaving DONE.
- Asynchronous reset mid-XFER drops o_start on the next cycle. The partially written sample is abandoned and is not re-sent.

## Configuration
- OSC_DECIM_EN defined:
  - Adds input i_decim[15:0].
  - Only every (i_decim+1)th tick starts a sample. The decimation counter runs regardless of state.
  - Dropped ticks do not count as overrun.
- OSC_DECIM_EN undefined: i_decim does not exist, and every tick is eligible.

## Test plan
- Sample addressing: NUM_CH=2, i_done 3 cycles after o_start.
  - Two writes per tick: addresses 0x90_0000 and 0xA0_0000 with index 0.
  - Next tick uses 0x90_0008 and 0xA0_0008.
  - Exactly one GAP cycle between the writes.
- Ring wrap: DEPTH=4, six ticks.
  - o_addr_cnt sequence 0,1,2,3,0,1.
  - Sixth write to address BASE+8.
- Trigger and post count: armed, source ch0 upper, level=100, samples 50,99,100,120, i_post_cnt=2.
  - Fires on sample 100 with o_trg_idx=2.
  - o_frozen set after sample index 4; later ticks produce no o_start.
  - i_trg_arm clears the flags and capture resumes at index 5.
- Overrun: i_done held off for PERIOD+10 cycles.
  - o_overrun=1 and the tick is skipped.
  - The next sample uses index +1 with no duplicate write.
- Reset mid-XFER: assert i_rst while o_start=1.
  - All outputs 0 and state IDLE next cycle.
  - After release the first sample writes index 0.
- Decimation: with OSC_DECIM_EN and i_decim=2, o_start appears on ticks 3, 6 and 9 only.
